// File: rtl/handshake_crossing_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack crossing channel among REQUESTERS sources.
// Optional per-phase watchdog: define HANDSHAKE_CROSSING_ARBITER_TIMEOUT_EN.
module handshake_crossing_arbiter #(
   parameter int unsigned REQUESTERS     = 4,
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [REQUESTERS-1:0]            request,
   input  logic [REQUESTERS*DATA_WIDTH-1:0] request_data,
   output logic [REQUESTERS-1:0]            grant,
   output logic                             busy,
   output logic                             crossing_request,
   output logic [DATA_WIDTH-1:0]            crossing_data,
   input  logic                             crossing_acknowledge
`ifdef HANDSHAKE_CROSSING_ARBITER_TIMEOUT_EN
   ,
   output logic                             timeout
`endif
);

   localparam int unsigned IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

   if (REQUESTERS < 2 || TIMEOUT_CYCLES == 0) begin : g_param_check
      $error("handshake_crossing_arbiter: REQUESTERS must be >= 2 and TIMEOUT_CYCLES > 0");
   end

   typedef enum logic [1:0] {
      IDLE,
      REQUEST,
      RELEASE
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [IDX_W-1:0]       pointer;
   logic [IDX_W-1:0]       pointer_next;
   logic [IDX_W-1:0]       winner;
   logic [IDX_W-1:0]       winner_next;
   logic [IDX_W-1:0]       winner_inc;
   logic [IDX_W-1:0]       pick;
   logic                   found;
   logic [REQUESTERS-1:0]  grant_next;
   logic                   busy_next;
   logic                   crossing_request_next;
   logic [DATA_WIDTH-1:0]  crossing_data_next;
   logic [DATA_WIDTH-1:0]  slots [REQUESTERS];

`ifdef HANDSHAKE_CROSSING_ARBITER_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] counter_next;
   logic             expired;
   logic             timeout_next;
`endif

   for (genvar g = 0; g < REQUESTERS; g++) begin : g_slot
      assign slots[g] = request_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // Rotating priority: first asserted request at or above pointer, wrapping.
   always_comb begin
      int unsigned      idx;
      logic [IDX_W-1:0] cand;
      found = 1'b0;
      pick  = '0;
      for (int unsigned k = 0; k < REQUESTERS; k++) begin
         idx  = (32'(pointer) + k) % REQUESTERS;
         cand = IDX_W'(idx);
         if (!found && request[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign winner_inc = (winner == IDX_W'(REQUESTERS - 1)) ? '0 : winner + 1'b1;

`ifdef HANDSHAKE_CROSSING_ARBITER_TIMEOUT_EN
   assign expired = ((32'(counter) + 1) == TIMEOUT_CYCLES);
`endif

   always_comb begin
      state_next            = state;
      pointer_next          = pointer;
      winner_next           = winner;
      crossing_request_next = crossing_request;
      crossing_data_next    = crossing_data;
      grant_next            = '0;
`ifdef HANDSHAKE_CROSSING_ARBITER_TIMEOUT_EN
      timeout_next          = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (!crossing_acknowledge && found) begin
               winner_next           = pick;
               crossing_data_next    = slots[pick];
               crossing_request_next = 1'b1;
               state_next            = REQUEST;
            end
         end
         REQUEST: begin
            if (crossing_acknowledge) begin
               crossing_request_next = 1'b0;
               grant_next[winner]    = 1'b1;
               state_next            = RELEASE;
            end
`ifdef HANDSHAKE_CROSSING_ARBITER_TIMEOUT_EN
            else if (expired) begin
               crossing_request_next = 1'b0;
               timeout_next          = 1'b1;
               state_next            = RELEASE;
            end
`endif
         end
         RELEASE: begin
            if (!crossing_acknowledge) begin
               pointer_next = winner_inc;
               state_next   = IDLE;
            end
`ifdef HANDSHAKE_CROSSING_ARBITER_TIMEOUT_EN
            else if (expired) begin
               timeout_next = 1'b1;
               pointer_next = winner_inc;
               state_next   = IDLE;
            end
`endif
         end
         default: state_next = IDLE;
      endcase
      busy_next = (state_next != IDLE);
`ifdef HANDSHAKE_CROSSING_ARBITER_TIMEOUT_EN
      counter_next = (state_next != state || state == IDLE) ? '0 : counter + 1'b1;
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         pointer          <= '0;
         winner           <= '0;
         crossing_request <= 1'b0;
         crossing_data    <= '0;
         grant            <= '0;
         busy             <= 1'b0;
`ifdef HANDSHAKE_CROSSING_ARBITER_TIMEOUT_EN
         counter          <= '0;
         timeout          <= 1'b0;
`endif
      end else begin
         state            <= state_next;
         pointer          <= pointer_next;
         winner           <= winner_next;
         crossing_request <= crossing_request_next;
         crossing_data    <= crossing_data_next;
         grant            <= grant_next;
         busy             <= busy_next;
`ifdef HANDSHAKE_CROSSING_ARBITER_TIMEOUT_EN
         counter          <= counter_next;
         timeout          <= timeout_next;
`endif
      end
   end

endmodule
